mux_arb_nto1: RTL and testbench

//  Parametrised N-to-1 registered channel mux with built-in arbitration and

---
 rtl/mux_arb_nto1_if.sv | 23 ++
 rtl/mux_arb_nto1.sv | 51 +++++
 tb/tb_mux_arb_nto1.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mux_arb_nto1_if.sv
// mux_arb_nto1_if: channel/consumer handshake bundle for mux_arb_nto1.
// Carries lock_i only when MUX_ARB_LOCK_EN is defined.
interface mux_arb_nto1_if #(
    parameter int size = 32,
    parameter int NUM_CH = 4,
    parameter int SEL_W = 2
);
    logic [NUM_CH*size-1:0] data_i;
    logic [NUM_CH-1:0]      valid_i;
    logic [NUM_CH-1:0]      ready_o;
    logic [size-1:0]        data_o;
    logic                   valid_o;
    logic                   ready_i;
    logic [SEL_W-1:0]       grant_o;
`ifdef MUX_ARB_LOCK_EN
    logic                   lock_i;
    modport slave (input data_i, valid_i, ready_i, lock_i, output ready_o, data_o, valid_o, grant_o);
    modport master (output data_i, valid_i, ready_i, lock_i, input ready_o, data_o, valid_o, grant_o);
`else
    modport slave (input data_i, valid_i, ready_i, output ready_o, data_o, valid_o, grant_o);
    modport master (output data_i, valid_i, ready_i, input ready_o, data_o, valid_o, grant_o);
`endif
endinterface

// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1: N-to-1 registered channel mux with fixed-priority or round-robin arbitration.
// Define MUX_ARB_LOCK_EN to add lock_i, which pins the grant to the last transferred channel.
module mux_arb_nto1 #(
    parameter int size = 32,
    parameter int NUM_CH = 4,
    parameter int SEL_W = 2,
    parameter int RR_MODE = 1
) (
    input logic           clk_i,
    input logic           rst_i,
    mux_arb_nto1_if.slave bus
);
    logic [SEL_W-1:0] last, pick, winner;
    logic             can_load, xfer;
    // Descending scan so the earliest channel in search order overrides later ones.
    always_comb begin
        pick = last;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (bus.valid_i[(RR_MODE != 0 ? int'(last) + 1 + i : i) % NUM_CH])
                pick = SEL_W'((RR_MODE != 0 ? int'(last) + 1 + i : i) % NUM_CH);
    end
`ifdef MUX_ARB_LOCK_EN
    logic locked;
    assign winner = locked ? last : pick;
    always_ff @(posedge clk_i) begin
        if (!rst_i) locked <= 1'b0;
        else if (xfer) locked <= bus.lock_i;
    end
`else
    assign winner = pick;
`endif
    assign can_load = !bus.valid_o | bus.ready_i;
    for (genvar k = 0; k < NUM_CH; k++)
        assign bus.ready_o[k] = rst_i & can_load & bus.valid_i[k] & (winner == SEL_W'(k));
    assign xfer = |bus.ready_o;
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            bus.valid_o <= 1'b0;
            bus.data_o  <= '0;
            bus.grant_o <= '0;
            last        <= SEL_W'(NUM_CH - 1);
        end else if (xfer) begin
            bus.valid_o <= 1'b1;
            bus.data_o  <= bus.data_i[int'(winner)*size +: size];
            bus.grant_o <= winner;
            last        <= winner;
        end else if (bus.ready_i) begin
            bus.valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_arb_nto1.sv
// tb_mux_arb_nto1: vector table, corner sequences and random traffic checked against a
// behavioural model, on one round-robin and one fixed-priority instance.
module tb_mux_arb_nto1;
    logic         clk = 1'b0;
    logic         rst, rdy, lock;
    logic [3:0]   valid;
    logic [127:0] data;
    logic [3:0]   cap_rr, cap_fp;
    int           n_cmp = 0, n_err = 0;
    bit           mv[2], mk[2];
    logic [31:0]  md[2];
    int           mg[2], ml[2];

    always #5 clk = ~clk;

    mux_arb_nto1_if #(.size(32), .NUM_CH(4), .SEL_W(2)) if_rr ();
    mux_arb_nto1_if #(.size(32), .NUM_CH(4), .SEL_W(2)) if_fp ();
    assign if_rr.data_i = data;
    assign if_rr.valid_i = valid;
    assign if_rr.ready_i = rdy;
    assign if_fp.data_i = data;
    assign if_fp.valid_i = valid;
    assign if_fp.ready_i = rdy;
`ifdef MUX_ARB_LOCK_EN
    assign if_rr.lock_i = lock;
    assign if_fp.lock_i = lock;
`endif

    mux_arb_nto1 #(.size(32), .NUM_CH(4), .SEL_W(2), .RR_MODE(1)) dut_rr (.clk_i(clk), .rst_i(rst), .bus(if_rr));
    mux_arb_nto1 #(.size(32), .NUM_CH(4), .SEL_W(2), .RR_MODE(0)) dut_fp (.clk_i(clk), .rst_i(rst), .bus(if_fp));

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: m=0 round-robin instance, m=1 fixed-priority instance.
    function automatic logic [3:0] m_ready(int m);
        int ch;
        if (!rst || (mv[m] && !rdy)) return 4'h0;
        if (mk[m]) return valid[ml[m]] ? 4'(1 << ml[m]) : 4'h0;
        for (int i = 0; i < 4; i++) begin
            ch = (m == 0) ? (ml[m] + 1 + i) % 4 : i;
            if (valid[ch]) return 4'(1 << ch);
        end
        return 4'h0;
    endfunction

    task automatic m_update(int m, logic [3:0] r);
        if (!rst) begin
            mv[m] = 0; md[m] = '0; mg[m] = 0; ml[m] = 3; mk[m] = 0;
        end else if (r != 0) begin
            for (int c = 0; c < 4; c++)
                if (r[c]) begin
                    md[m] = data[c*32 +: 32]; mg[m] = c; ml[m] = c; mv[m] = 1; mk[m] = lock;
                end
        end else if (rdy) mv[m] = 0;
    endtask

    // Called at a negedge with inputs driven; returns at the following negedge.
    task automatic cycle();
        logic [3:0] er0, er1;
        er0 = m_ready(0);
        er1 = m_ready(1);
        #1;
        cap_rr = if_rr.ready_o;
        cap_fp = if_fp.ready_o;
        chk("rr_ready", {28'h0, cap_rr}, {28'h0, er0});
        chk("fp_ready", {28'h0, cap_fp}, {28'h0, er1});
        @(posedge clk);
        m_update(0, er0);
        m_update(1, er1);
        @(negedge clk);
        chk("rr_valid", {31'h0, if_rr.valid_o}, {31'h0, mv[0]});
        chk("rr_data", if_rr.data_o, md[0]);
        chk("rr_grant", {30'h0, if_rr.grant_o}, 32'(mg[0]));
        chk("fp_valid", {31'h0, if_fp.valid_o}, {31'h0, mv[1]});
        chk("fp_data", if_fp.data_o, md[1]);
        chk("fp_grant", {30'h0, if_fp.grant_o}, 32'(mg[1]));
    endtask

    typedef struct {
        logic [3:0] valid;
        logic       rdy;
        logic [3:0] rr_rdy, fp_rdy;
        logic [1:0] rr_g, fp_g;
        logic       vo;
    } vec_t;
    vec_t tbl[11];

    initial begin
        tbl[0]  = '{4'hF, 1'b1, 4'h1, 4'h1, 2'd0, 2'd0, 1'b1};
        tbl[1]  = '{4'hF, 1'b1, 4'h2, 4'h1, 2'd1, 2'd0, 1'b1};
        tbl[2]  = '{4'hF, 1'b1, 4'h4, 4'h1, 2'd2, 2'd0, 1'b1};
        tbl[3]  = '{4'hF, 1'b1, 4'h8, 4'h1, 2'd3, 2'd0, 1'b1};
        tbl[4]  = '{4'hF, 1'b1, 4'h1, 4'h1, 2'd0, 2'd0, 1'b1};
        tbl[5]  = '{4'hA, 1'b1, 4'h2, 4'h2, 2'd1, 2'd1, 1'b1};
        tbl[6]  = '{4'hA, 1'b1, 4'h8, 4'h2, 2'd3, 2'd1, 1'b1};
        tbl[7]  = '{4'hA, 1'b1, 4'h2, 4'h2, 2'd1, 2'd1, 1'b1};
        tbl[8]  = '{4'h0, 1'b1, 4'h0, 4'h0, 2'd1, 2'd1, 1'b0};
        tbl[9]  = '{4'h4, 1'b0, 4'h4, 4'h4, 2'd2, 2'd2, 1'b1};
        tbl[10] = '{4'h1, 1'b0, 4'h0, 4'h0, 2'd2, 2'd2, 1'b1};
        for (int m = 0; m < 2; m++) begin
            mv[m] = 0; md[m] = '0; mg[m] = 0; ml[m] = 3; mk[m] = 0;
        end
        for (int k = 0; k < 4; k++) data[k*32 +: 32] = 32'hA000_0000 + k;
        rst = 1'b0; valid = 4'hF; rdy = 1'b0; lock = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        chk("rst_valid", {31'h0, if_rr.valid_o}, 32'h0);
        chk("rst_data", if_rr.data_o, 32'h0);
        chk("rst_grant", {30'h0, if_rr.grant_o}, 32'h0);
        chk("rst_ready", {28'h0, cap_rr | cap_fp}, 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 11; i++) begin
            valid = tbl[i].valid;
            rdy = tbl[i].rdy;
            cycle();
            chk($sformatf("tbl%0d_rr_ready", i), {28'h0, cap_rr}, {28'h0, tbl[i].rr_rdy});
            chk($sformatf("tbl%0d_fp_ready", i), {28'h0, cap_fp}, {28'h0, tbl[i].fp_rdy});
            chk($sformatf("tbl%0d_rr_grant", i), {30'h0, if_rr.grant_o}, {30'h0, tbl[i].rr_g});
            chk($sformatf("tbl%0d_fp_grant", i), {30'h0, if_fp.grant_o}, {30'h0, tbl[i].fp_g});
            chk($sformatf("tbl%0d_valid", i), {31'h0, if_rr.valid_o}, {31'h0, tbl[i].vo});
            chk($sformatf("tbl%0d_rr_data", i), if_rr.data_o, 32'hA000_0000 + 32'(tbl[i].rr_g));
        end
        // Backpressure: park ch2's word, stall 5 cycles, then refill from ch0 with no bubble.
        rst = 1'b0; cycle(); rst = 1'b1;
        data[64 +: 32] = 32'hDEAD_BEEF;
        valid = 4'h4; rdy = 1'b0;
        cycle();
        valid = 4'h1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_ready", {28'h0, cap_rr}, 32'h0);
            chk("bp_data", if_rr.data_o, 32'hDEAD_BEEF);
            chk("bp_grant", {30'h0, if_rr.grant_o}, 32'd2);
        end
        rdy = 1'b1;
        cycle();
        chk("bp_release_data", if_rr.data_o, 32'hA000_0000);
        chk("bp_release_valid", {31'h0, if_rr.valid_o}, 32'h1);
        // Drain to empty; the pointer stays on ch0 so the next RR grant is ch1.
        valid = 4'h0;
        cycle();
        chk("drain_valid", {31'h0, if_rr.valid_o}, 32'h0);
        chk("drain_hold", if_rr.data_o, 32'hA000_0000);
        valid = 4'hF;
        cycle();
        chk("drain_next_rr", {30'h0, if_rr.grant_o}, 32'd1);
        chk("drain_next_fp", {30'h0, if_fp.grant_o}, 32'd0);
`ifdef MUX_ARB_LOCK_EN
        rst = 1'b0; cycle(); rst = 1'b1;
        valid = 4'h2; lock = 1'b1;
        cycle();
        chk("lock_g0", {30'h0, if_rr.grant_o}, 32'd1);
        valid = 4'hF;
        for (int i = 1; i < 4; i++) begin
            if (i == 3) lock = 1'b0;
            cycle();
            chk("lock_g", {30'h0, if_rr.grant_o}, 32'd1);
            chk("lock_fp_g", {30'h0, if_fp.grant_o}, 32'd1);
        end
        cycle();
        chk("unlock_rr", {30'h0, if_rr.grant_o}, 32'd2);
        chk("unlock_fp", {30'h0, if_fp.grant_o}, 32'd0);
`endif
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) != 0);
            valid = 4'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 3) != 0);
            data = {$urandom, $urandom, $urandom, $urandom};
`ifdef MUX_ARB_LOCK_EN
            lock = ($urandom_range(0, 3) == 0);
`endif
            cycle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
